// File: rtl/bin_row_packer.sv
// -----------------------------------------------------------------------------
// bin_row_packer
//
// Thresholds a 16-bit grayscale pixel stream to one bit per pixel, packs
// PACK_W pixels (LSB = lowest column) into words, and queues those words in a
// small first-word-fall-through FIFO that the HPS drains with valid/ready.
// Alongside the packed image it reports the number of set pixels in each row
// so software can segment digits by row projection.
//
// Ports:
//   iCLK         single clock for all logic
//   iRST         synchronous, active-high reset (aborts frame, flushes FIFO)
//   iSTART       frame start request, level-sampled in IDLE
//   iDATA        pixel value
//   iDVAL        iDATA valid this cycle
//   iTHRESHOLD   binarisation threshold (pixel set when iDATA > threshold)
//   oWORD        head of the packed-word FIFO (0 when empty)
//   oWORD_VALID  FIFO not empty
//   iWORD_READY  consumer pops the head when high together with oWORD_VALID
//   oROW_COUNT   set-pixel count of the last completed row (saturates at 1023)
//   oROW_IDX     index of the last completed row
//   oROW_VALID   one-cycle pulse: oROW_COUNT / oROW_IDX are new
//   oBUSY        high while a frame is running or draining
//   oFRAME_DONE  one-cycle pulse in the first IDLE cycle after a frame
//   oOVERFLOW    sticky: a packed word was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module bin_row_packer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int DATA_W     = 16,
    parameter int PACK_W     = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [9:0]        iTHRESHOLD,
    output logic [PACK_W-1:0] oWORD,
    output logic              oWORD_VALID,
    input  logic              iWORD_READY,
    output logic [9:0]        oROW_COUNT,
    output logic [8:0]        oROW_IDX,
    output logic              oROW_VALID,
    output logic              oBUSY,
    output logic              oFRAME_DONE,
    output logic              oOVERFLOW
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int BIT_W = $clog2(PACK_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [8:0]        row;
    logic [PACK_W-1:0] pack;
    logic [9:0]        row_cnt;

    // FIFO storage and bookkeeping
    logic [PACK_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    // Datapath decode
    logic              accept;
    logic              pix_bit;
    logic [BIT_W-1:0]  bit_idx;
    logic              word_end;
    logic              row_end;
    logic              last_pix;
    logic [PACK_W-1:0] pack_next;
    logic [9:0]        row_cnt_next;
    logic              push;
    logic              pop;
    logic              empty;
    logic              full;
    logic              wr_en;

    // NOTE: every signal assigned in always_comb gets a default at the top so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        accept   = (state == RUN) && iDVAL;
        pix_bit  = iDATA > DATA_W'(iTHRESHOLD);
        // IMG_W is a multiple of PACK_W, so the low column bits are the bit slot.
        bit_idx  = col[BIT_W-1:0];
        word_end = &bit_idx;
        row_end  = (col == COL_W'(IMG_W - 1));
        last_pix = row_end && (row == 9'(IMG_H - 1));

        pack_next = pack | ({{(PACK_W-1){1'b0}}, pix_bit} << bit_idx);

        row_cnt_next = row_cnt;
        if (pix_bit && (row_cnt != 10'd1023))
            row_cnt_next = row_cnt + 10'd1;

        empty = (fifo_count == '0);
        full  = (fifo_count == CNT_W'(FIFO_DEPTH));
        push  = accept && word_end;
        pop   = !empty && iWORD_READY;
        // A push into a full FIFO still lands when the head leaves this cycle.
        wr_en = push && (!full || pop);
    end

    assign oBUSY       = (state == RUN) || (state == DRAIN);
    assign oWORD_VALID = !empty;
    assign oWORD       = empty ? '0 : mem[rd_ptr];

    // Frame control, counters, packing and row statistics.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            pack        <= '0;
            row_cnt     <= '0;
            oROW_COUNT  <= '0;
            oROW_IDX    <= '0;
            oROW_VALID  <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            oROW_VALID  <= 1'b0;
            oFRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        state   <= RUN;
                        col     <= '0;
                        row     <= '0;
                        pack    <= '0;
                        row_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        pack <= word_end ? '0 : pack_next;
                        if (row_end) begin
                            col        <= '0;
                            row        <= row + 9'd1;
                            row_cnt    <= '0;
                            oROW_COUNT <= row_cnt_next;
                            oROW_IDX   <= row;
                            oROW_VALID <= 1'b1;
                        end else begin
                            col     <= col + COL_W'(1);
                            row_cnt <= row_cnt_next;
                        end
                        if (last_pix)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state       <= IDLE;
                        oFRAME_DONE <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            oOVERFLOW  <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && full && !pop)
                oOVERFLOW <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and oWORD is gated to zero while empty, so stale contents are
    // never visible.
    always_ff @(posedge iCLK) begin
        if (wr_en)
            mem[wr_ptr] <= pack_next;
    end

endmodule
